// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e     : controller FSM states
//   CNT_W       : latency counter width (covers LATENCY up to 15)
//   merge_bytes : byte-enable merge of a store into an existing word
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 4;

  // Byte i of the result comes from new_word when be[i] is set, else from old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage bank: DEPTH x 32 bits.
// Synchronous byte-enabled write, asynchronous read by word index. Contents are not reset.
// Ports:
//   clk   : write clock
//   we    : write strobe
//   be    : per-byte write enables
//   widx  : write word index
//   wdata : write data
//   ridx  : read word index
//   rdata : read data (combinational)
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= merge_bytes(mem[widx], wdata, be);
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory responder for the core's load/store port.
// One transaction in flight; request accepted only in IDLE, response presented in RESP after
// LATENCY cycles. Stores commit at the acceptance edge; misaligned or out-of-range requests
// leave storage untouched and answer with rsp_err=1, rsp_rdata=0.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (req_ready high only in IDLE)
//   req_we, req_addr      : 1=store/0=load, byte address
//   req_wdata, req_be     : store data and byte enables
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_err    : load data (0 for stores/errors), error flag
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rerr_q, rerr_d;

  logic             accept;
  logic             req_err;
  logic [AW-1:0]    req_idx;
  logic             bank_we;
  logic [31:0]      bank_rdata;

  assign accept  = req_valid && (state_q == IDLE);
  // Word index beyond DEPTH is an error rather than wrapping, so compare the full word address.
  assign req_err = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign req_idx = req_addr[AW+1:2];
  assign bank_we = accept && req_we && !req_err;

  dmem_bank #(
    .DEPTH(DEPTH)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .be   (req_be),
    .widx (req_idx),
    .wdata(req_wdata),
    .ridx (idx_q),
    .rdata(bank_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          we_d    = req_we;
          idx_d   = req_idx;
          err_d   = req_err;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = (we_q || err_q) ? 32'h0 : bank_rdata;
          rerr_d  = err_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          rerr_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Handshake outputs decode only the state register; no path from req_valid or rsp_ready.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

  // Store data and byte enables are consumed at acceptance; nothing else needs them.
  logic unused_wdata;
  assign unused_wdata = ^{req_wdata, req_be} & 1'b0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: table-driven transactions with a response scoreboard,
// plus hand-written backpressure, reset-abort and latency/throughput sequences.
module tb_dmem_ctrl;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        rv_l1 = 1'b0, rv_l15 = 1'b0;
  logic        rr_l1, rr_l15, sv_l1, sv_l15, re_l1, re_l15;
  logic [31:0] rd_l1, rd_l15;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(64), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_ctrl #(.DEPTH(16), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(rv_l1), .req_ready(rr_l1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(sv_l1),
    .rsp_ready(rsp_ready), .rsp_rdata(rd_l1), .rsp_err(re_l1)
  );

  dmem_ctrl #(.DEPTH(16), .LATENCY(15)) dut_l15 (
    .clk(clk), .reset(reset), .req_valid(rv_l15), .req_ready(rr_l15), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(sv_l15),
    .rsp_ready(rsp_ready), .rsp_rdata(rd_l15), .rsp_err(re_l15)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] rdata, input logic err,
                      input bit push);
    exp_t e;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    check("req_ready before accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    if (push) begin
      e.rdata = rdata;
      e.err   = err;
      sb.push_back(e);
    end
    #1 req_valid = 1'b0;
  endtask

  // Waits for rsp_valid, checks latency and scoreboard; consumes if rsp_ready is high.
  task automatic collect();
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check("response latency", n, LAT);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: response with no expected entry, got %h", rsp_rdata);
    end else begin
      e = sb.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
    end
    if (rsp_ready) begin
      @(posedge clk);
      #1;
      check("rsp_valid cleared", {31'b0, rsp_valid}, 32'd0);
      check("rsp_rdata cleared", rsp_rdata, 32'd0);
      check("req_ready after resp", {31'b0, req_ready}, 32'd1);
    end
  endtask

  // Holds req_valid on a small instance and checks first response and back-to-back period.
  task automatic sweep(input bit use15, input int lat);
    int  first, second, k;
    bit  prev, cur;
    req_we = 1'b1;
    req_addr = 32'h4;
    req_wdata = 32'h12345678;
    req_be = 4'h0;
    rsp_ready = 1'b1;
    check("sweep idle ready", {31'b0, (use15 ? rr_l15 : rr_l1)}, 32'd1);
    if (use15) rv_l15 = 1'b1; else rv_l1 = 1'b1;
    first = -1;
    second = -1;
    prev = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      cur = use15 ? sv_l15 : sv_l1;
      if (cur) begin
        check("sweep rdata", use15 ? rd_l15 : rd_l1, 32'd0);
        check("sweep err", {31'b0, (use15 ? re_l15 : re_l1)}, 32'd0);
      end
      if (cur && !prev) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      prev = cur;
    end
    rv_l1 = 1'b0;
    rv_l15 = 1'b0;
    check("sweep first response", first, lat + 1);
    check("sweep period", second - first, lat + 2);
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h13,       32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h0,        32'h01020304, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h100,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h0,        32'h0,        4'h3, 32'h01020304, 1'b0};
    vecs[9]  = '{1'b1, 32'h22,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[11] = '{1'b1, 32'hFC,       32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'hFC,       32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b0, 32'hFFFFFFF0, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 32'h0,        32'h99999999, 4'h0, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h01020304, 1'b0};

    // Reset state
    #12;
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rdata, vecs[i].err, 1'b1);
      collect();
    end

    // Backpressure: response held, a competing store must not be accepted.
    rsp_ready = 1'b0;
    send(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    collect();
    req_we = 1'b1;
    req_addr = 32'h10;
    req_wdata = 32'h0BADF00D;
    req_be = 4'hF;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release", {31'b0, rsp_valid}, 32'd0);
    send(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    collect();

    // Reset during WAIT: committed store survives, aborted load never responds.
    send(1'b1, 32'h8, 32'h5, 4'hF, 32'h0, 1'b0, 1'b1);
    collect();
    send(1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    check("load accepted (in WAIT)", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort req_ready", {31'b0, req_ready}, 32'd1);
    check("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    seen = 1'b0;
    repeat (LAT + 3) begin
      @(posedge clk);
      #1 seen |= rsp_valid;
    end
    check("no aborted response", {31'b0, seen}, 32'd0);
    check("ready after abort", {31'b0, req_ready}, 32'd1);
    send(1'b0, 32'h8, 32'h0, 4'h0, 32'h5, 1'b0, 1'b1);
    collect();

    // Latency extremes and back-to-back period.
    sweep(1'b0, 1);
    sweep(1'b1, 15);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Multi-cycle data-memory responder for the MIPS core's load/store port. It replaces the zero-latency combinational data memory with a request/response handshake, programmable access latency, byte-enable writes, and error signalling for misaligned or out-of-range addresses. It sits between the processor's data port (initiator) and an internal word-organised storage bank. It serves one outstanding transaction at a time.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, 4..4096
- `LATENCY`, 2: cycles from request acceptance to response valid; 1..15
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; low clears control state immediately
- `req_valid` in 1: initiator presents a request
- `req_ready` out 1: responder can accept; high only in IDLE
- `req_we` in 1: 1 = store, 0 = load
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data
- `req_be` in 4: byte enables; bit i covers `req_wdata[8i+7:8i]`
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: initiator consumes response
- `rsp_rdata` out 32: load data; 0 for stores and errors
- `rsp_err` out 1: request was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, capture we/addr/wdata/be, load `cnt` with LATENCY-1, go to WAIT.
- Error check at acceptance: err = (`req_addr[1:0]`!=0) || (`req_addr[31:2]` >= DEPTH).
- Stores commit at the acceptance edge when err=0. Only bytes with `req_be[i]`=1 are written. be=4'b0000 is a legal no-op store and still gets a response.
- WAIT: if `cnt`==0, sample the storage word at the captured index (loads, no error) into `rsp_rdata` and go to RESP. Otherwise decrement `cnt`.
- RESP: `rsp_valid`=1. `rsp_rdata`/`rsp_err` are held stable. On `rsp_ready`, go to IDLE and clear `rsp_valid`, `rsp_rdata` and `rsp_err`.
- Loads ignore `req_be`; they always return the full word.
- An erroring request does not touch storage. It responds with `rsp_err`=1 and `rsp_rdata`=0 after the normal latency.
- The word index is `req_addr[log2(DEPTH)+1:2]`. There is no wrap-around; indices at or beyond DEPTH are errors.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `cnt`=0.
  - Storage contents are not reset.
- Latency: if accepted at edge t, `rsp_valid` rises after edge t+LATENCY. With `rsp_ready` held high, it falls after edge t+LATENCY+1.
- Throughput: no acceptance while in WAIT/RESP. The earliest next acceptance is the edge after the RESP→IDLE edge. Minimum period is LATENCY+2 cycles.
- `req_ready` is a pure function of state, with no combinational path from `req_valid`.
- Outputs are registered; there is no combinational path from `rsp_ready`.
- A load issued right after a store to the same word returns the new data, since the store commits at acceptance.
- Backpressure: `rsp_ready`=0 holds RESP indefinitely, with outputs stable.
- Reset asserted mid-transaction:
  - The pending response is discarded and the FSM returns to IDLE.
  - A store already accepted stays committed.
  - No `rsp_valid` is produced for the aborted request.

## Structure
- Shared package `dmem_pkg`: state enum (IDLE, WAIT, RESP), `CNT_W`=4, helper function for byte-mask merge.
- Sub-module `dmem_bank`: DEPTH×32 synchronous-write storage with 4-bit byte-write enable and asynchronous read by index.
- `dmem_ctrl` holds the FSM, capture registers, latency counter and error check.

## Test plan
- Reset then store/load: store 0xDEADBEEF at 0x10 with be=4'hF, then load 0x10 → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0. `rsp_valid` rises exactly LATENCY cycles after each acceptance.
- Byte enables: store 0x11223344 at 0x20 (be=F), then store 0xAABBCCDD with be=4'b0101, then load → 0x11BB33DD.
- Errors:
  - Load 0x13 → `rsp_err`=1, `rsp_rdata`=0.
  - Store to 0x100 with DEPTH=64 → `rsp_err`=1. A following load of word 0 is unchanged.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_rdata` and `req_ready`=0 stay stable. A new `req_valid` during this time is not accepted.
- Reset mid-WAIT:
  - Store 0x5 at 0x8, then issue a load of 0x8.
  - Assert reset while in WAIT → no response, `req_ready`=1 after release.
  - Reload 0x8 → 0x5.
- Latency sweep: LATENCY=1 and LATENCY=15 → response at t+1 and t+15. The back-to-back request period is LATENCY+2.
